pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Parametrised successor of the 5-stage stall/flush controller. Generates per-stage stall/flush vectors for an N-stage in-order pipeline.
- Detects load-use hazards across a configurable number of decode source operands.
- Owns a registered fetch-redirect FSM covering taken branches, wrong-path drain and exception vectoring.
- Sits beside the datapath; stage 0 = fetch, 1 = decode, 2 = execute, N-1 = write back.

Parameters:
- NUM_STAGES, 5, pipeline depth (legal range 3..8).
- ADDR_WIDTH, 32, PC/target width.
- PREG_WIDTH, 6, physical register address width.
- NUM_SRC, 2, decode source operands checked for load-use (1..3).
- EXC_WIDTH, 4, exception code width; code 0 = none.
- EXC_ERET_CODE, 15, code that redirects to epc.
- EXC_BASE, 32'h0000_0100, base of the exception vector table.
- VEC_SHIFT, 3, vector = EXC_BASE + (code << VEC_SHIFT).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- run  in  1  core enabled (external storage ready and not halted).
- stage_busy  in  NUM_STAGES  bit i = stage i has not finished its current operation.
- regfile_stall  in  1  register-file port conflict; stalls decode.
- dec_branch  in  1  decode holds a branch.
- dec_src_en  in  NUM_SRC  per-source valid.
- dec_src_addr  in  NUM_SRC*PREG_WIDTH  packed source addresses; source k at [k*PREG_WIDTH +: PREG_WIDTH].
- exec_load  in  1  execute holds a load that writes a register.
- exec_wr_addr  in  PREG_WIDTH  load destination.
- br_take  in  1  execute resolved taken branch.
- br_target  in  ADDR_WIDTH  branch target.
- exception  in  EXC_WIDTH  committed exception code.
- epc  in  ADDR_WIDTH  return address for ERET.
- stall  out  NUM_STAGES  per-stage hold.
- flush  out  NUM_STAGES  per-stage bubble on output.
- global_flush  out  1  one-cycle pipeline kill.
- redirect_valid  out  1  fetch must load redirect_target.
- redirect_target  out  ADDR_WIDTH  new PC.
- load_use  out  1  load-use bubble inserted this cycle.

Behaviour:
- Reset: rst_n is synchronous and active-low, sampled on the rising edge of clk.
  - While in reset: FSM = IDLE, drain = 0, global_flush = 0, held target = 0.
  - Combinational outputs then follow from run and the other inputs.
  - Asserting reset mid-redirect abandons the redirect.
- run = 0: stall and flush all ones; redirect_valid = 0; registered state holds.
- Stall chain: stall[i] = stage_busy[i] | stall[i+1] | local[i], evaluated from N-1 down to 0.
  - local[1] = load_use | (dec_branch & stage_busy[0]) | regfile_stall.
  - local for every other stage = 0.
- Flush, per stage:
  - flush[i] = stage_busy[i] for i ≥ 2.
  - flush[1] = load_use | (dec_branch & stage_busy[0]) | br_take.
  - flush[0] = stage_busy[0] | br_take | drain.
- load_use = exec_load & OR over k of (dec_src_en[k] & dec_src_addr[k] == exec_wr_addr). One bubble per load.
- Redirect FSM states:
  - IDLE: redirect_valid = br_take, redirect_target = br_target, both combinational.
    - If br_take & stall[0]: latch br_target and go to PEND.
  - PEND: redirect_valid = 1, target = held register.
    - Return to IDLE on the first edge where stall[0] = 0.
  - Exception (exception ≠ 0 at an edge): from any state, latch the vector (epc if code = EXC_ERET_CODE), go to PEND, and set global_flush = 1 for the next cycle only.
  - Exception beats a simultaneous br_take.
  - An exception held for k cycles re-latches each cycle.
  - A br_take in PEND replaces the held target.
- Drain: set when br_take & stage_busy[0] at an edge; cleared at the first edge with stage_busy[0] = 0.
  - flush[0] stays high throughout, including that final cycle.
  - Ensures the wrong-path fetch completing late is discarded.
- Latency: branch redirect 0 cycles when fetch is free; exception redirect 1 cycle.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, add three 32-bit outputs, all reset to 0 and saturating at 32'hFFFF_FFFF:
  - perf_stall_cycles: counts cycles with run & stall[1].
  - perf_load_use: counts cycles with load_use.
  - perf_redirects: counts edges entering PEND or taking an IDLE branch.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load-use: exec_load = 1, exec_wr_addr = 6'd9, dec_src_en = 2'b10, src1 = 9 -> load_use = 1, stall = 5'b00011, flush[1] = 1 for exactly that cycle; src1 = 8 -> no stall.
- Back-pressure: stage_busy = 5'b01000 (mem busy) -> stall = 5'b01111, flush = 5'b01000; run = 0 -> stall = flush = 5'b11111.
- Branch with fetch free: br_take = 1, br_target = 32'h0000_2040 -> same-cycle redirect_valid = 1 with that target, flush[1:0] = 2'b11, FSM stays IDLE.
- Branch with fetch busy 3 cycles: br_take pulse with stage_busy[0] high -> redirect_valid held 3 cycles at 32'h0000_2040, flush[0] high until fetch done, drops the cycle after.
- Exception: exception = 4'd2 -> next cycle global_flush = 1 (one cycle), redirect_target = 32'h0000_0110; exception = 4'd15, epc = 32'h0000_0abc -> target 32'h0000_0abc; exception with br_take -> vector wins.
- Reset mid-PEND: rst_n low one edge -> FSM IDLE, redirect_valid = 0, global_flush = 0; with PIPE_HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush vectors, load-use detection and fetch-redirect FSM for an N-stage in-order pipeline.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/load-use/redirect counters.
module pipeline_hazard_ctrl #(
  parameter int                    NUM_STAGES    = 5,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    PREG_WIDTH    = 6,
  parameter int                    NUM_SRC       = 2,
  parameter int                    EXC_WIDTH     = 4,
  parameter int                    EXC_ERET_CODE = 15,
  parameter logic [ADDR_WIDTH-1:0] EXC_BASE      = 32'h0000_0100,
  parameter int                    VEC_SHIFT     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [NUM_STAGES-1:0]         stage_busy,
  input  logic                          regfile_stall,
  input  logic                          dec_branch,
  input  logic [NUM_SRC-1:0]            dec_src_en,
  input  logic [NUM_SRC*PREG_WIDTH-1:0] dec_src_addr,
  input  logic                          exec_load,
  input  logic [PREG_WIDTH-1:0]         exec_wr_addr,
  input  logic                          br_take,
  input  logic [ADDR_WIDTH-1:0]         br_target,
  input  logic [EXC_WIDTH-1:0]          exception,
  input  logic [ADDR_WIDTH-1:0]         epc,
  output logic [NUM_STAGES-1:0]         stall,
  output logic [NUM_STAGES-1:0]         flush,
  output logic                          global_flush,
  output logic                          redirect_valid,
  output logic [ADDR_WIDTH-1:0]         redirect_target,
  output logic                          load_use
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_load_use,
  output logic [31:0]                   perf_redirects
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [EXC_WIDTH-1:0] ERET_CODE = EXC_ERET_CODE[EXC_WIDTH-1:0];

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   held_target;
  logic                    drain;
  logic                    src_hit;
  logic                    dec_stall;
  logic [NUM_STAGES-1:0]   local_stall;
  logic [NUM_STAGES-1:0]   stall_c;
  logic [NUM_STAGES-1:0]   flush_c;
  logic [ADDR_WIDTH-1:0]   exc_vec;
  logic                    exc_vld;

  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (dec_src_en[k] && (dec_src_addr[k*PREG_WIDTH +: PREG_WIDTH] == exec_wr_addr))
        src_hit = 1'b1;
    end
  end

  assign load_use  = exec_load & src_hit;
  assign dec_stall = load_use | (dec_branch & stage_busy[0]);

  always_comb begin
    local_stall    = '0;
    local_stall[1] = dec_stall | regfile_stall;
  end

  // A stage holds if it or any stage downstream of it cannot advance.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    stall_c = '0;
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      acc        = acc | stage_busy[i] | local_stall[i];
      stall_c[i] = acc;
    end
  end

  always_comb begin
    flush_c = stage_busy;
    flush_c[1] = dec_stall | br_take;
    flush_c[0] = stage_busy[0] | br_take | drain;
  end

  assign stall = run ? stall_c : '1;
  assign flush = run ? flush_c : '1;

  assign exc_vld = (exception != '0);
  assign exc_vec = (exception == ERET_CODE) ? epc
                 : EXC_BASE + (ADDR_WIDTH'(exception) << VEC_SHIFT);

  assign redirect_valid  = run & ((state == PEND) | br_take);
  assign redirect_target = (state == PEND) ? held_target : br_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      held_target  <= '0;
      drain        <= 1'b0;
      global_flush <= 1'b0;
    end else if (run) begin
      global_flush <= exc_vld;
      if (exc_vld) begin
        held_target <= exc_vec;
        state       <= PEND;
      end else if (br_take && ((state == PEND) || stall_c[0])) begin
        // A newer branch while pending must be presented even if fetch frees now.
        held_target <= br_target;
        state       <= PEND;
      end else if ((state == PEND) && !stall_c[0]) begin
        state <= IDLE;
      end

      if (br_take && stage_busy[0])
        drain <= 1'b1;
      else if (!stage_busy[0])
        drain <= 1'b0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_load_use     <= '0;
      perf_redirects    <= '0;
    end else begin
      if (run && stall_c[1] && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (load_use && (perf_load_use != '1))
        perf_load_use <= perf_load_use + 32'd1;
      if (run && (state == IDLE) && (exc_vld || br_take) && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
